// File: rtl/root_verify.sv
// Sequential check of a {number, sq_root, cube_root} triple using one shared shift-add multiplier.
// Optional feature macro: ROOT_VERIFY_ERR_EN (root_err flag and saturating remainders).
module root_verify (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] number,
  input  logic [15:0] sq_root,
  input  logic [10:0] cube_root,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        is_square,
  output logic        is_cube,
  output logic [31:0] sq_rem,
  output logic [31:0] cb_rem,
  output logic        root_err
);

  typedef enum logic [2:0] {IDLE, SQ, CB1, CB2, DONE} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, so results never overlap.
  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] num_r;
  logic [10:0] cb_r;
  logic [31:0] sq_prod;
  logic [32:0] mcand;
  logic [32:0] acc;
  logic [15:0] mplier;

  logic [32:0] acc_next;
  logic [31:0] sq_diff;
  logic [31:0] cb_diff;
  logic        sq_eq;
  logic        cb_eq;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // In CB2 acc_next is the full 33-bit cube on the final iteration.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    sq_diff  = num_r - sq_prod;
    cb_diff  = num_r - acc_next[31:0];
    sq_eq    = (sq_prod == num_r);
    cb_eq    = (acc_next == {1'b0, num_r});
  end

`ifdef ROOT_VERIFY_ERR_EN
  logic sq_over;
  logic cb_over;

  always_comb begin
    sq_over = (sq_prod > num_r);
    cb_over = (acc_next > {1'b0, num_r});
  end
`else
  assign root_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      num_r     <= 32'd0;
      cb_r      <= 11'd0;
      sq_prod   <= 32'd0;
      mcand     <= 33'd0;
      acc       <= 33'd0;
      mplier    <= 16'd0;
      is_square <= 1'b0;
      is_cube   <= 1'b0;
      sq_rem    <= 32'd0;
      cb_rem    <= 32'd0;
`ifdef ROOT_VERIFY_ERR_EN
      root_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            num_r  <= number;
            cb_r   <= cube_root;
            mcand  <= {17'd0, sq_root};
            mplier <= sq_root;
            acc    <= 33'd0;
            cnt    <= 5'd15;
            state  <= SQ;
          end
        end
        SQ, CB1, CB2: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            // Last iteration of this product: hand the result to the next multiply.
            case (state)
              SQ: begin
                sq_prod <= acc_next[31:0];
                mcand   <= {22'd0, cb_r};
                mplier  <= {5'd0, cb_r};
                acc     <= 33'd0;
                cnt     <= 5'd10;
                state   <= CB1;
              end
              CB1: begin
                mcand  <= {11'd0, acc_next[21:0]};
                mplier <= {5'd0, cb_r};
                acc    <= 33'd0;
                cnt    <= 5'd10;
                state  <= CB2;
              end
              default: begin
                is_square <= sq_eq;
                is_cube   <= cb_eq;
`ifdef ROOT_VERIFY_ERR_EN
                sq_rem    <= sq_over ? 32'd0 : sq_diff;
                cb_rem    <= cb_over ? 32'd0 : cb_diff;
                root_err  <= sq_over | cb_over;
`else
                sq_rem    <= sq_diff;
                cb_rem    <= cb_diff;
`endif
                cnt       <= 5'd0;
                state     <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_root_verify.sv
// Directed scoreboard bench for root_verify; expectations come from a 64-bit arithmetic model.
module tb_root_verify;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] number;
  logic [15:0] sq_root;
  logic [10:0] cube_root;
  logic        out_valid;
  logic        out_ready;
  logic        is_square;
  logic        is_cube;
  logic [31:0] sq_rem;
  logic [31:0] cb_rem;
  logic        root_err;

  int checks   = 0;
  int failures = 0;
  logic [66:0] exp_q[$];

  root_verify dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .number    (number),
    .sq_root   (sq_root),
    .cube_root (cube_root),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .is_square (is_square),
    .is_cube   (is_cube),
    .sq_rem    (sq_rem),
    .cb_rem    (cb_rem),
    .root_err  (root_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Result packing: {is_square, is_cube, root_err, sq_rem, cb_rem}
  function automatic logic [66:0] model(input logic [31:0] n, input logic [15:0] s,
                                        input logic [10:0] c);
    logic [63:0] n64, s2, c3, sd, cd;
    logic so, co, e;
    n64 = {32'd0, n};
    s2  = {48'd0, s} * {48'd0, s};
    c3  = {53'd0, c} * {53'd0, c} * {53'd0, c};
    sd  = n64 - s2;
    cd  = n64 - c3;
    so  = (s2 > n64);
    co  = (c3 > n64);
    e   = 1'b0;
`ifdef ROOT_VERIFY_ERR_EN
    if (so) sd = 64'd0;
    if (co) cd = 64'd0;
    e = so | co;
`endif
    return {(s2 == n64), (c3 == n64), e, sd[31:0], cd[31:0]};
  endfunction

  function automatic logic [66:0] fields();
    return {is_square, is_cube, root_err, sq_rem, cb_rem};
  endfunction

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: called at a negedge with the DUT in IDLE; returns at the negedge after accept
  task automatic drive(input logic [31:0] n, input logic [15:0] s, input logic [10:0] c);
    exp_q.push_back(model(n, s, c));
    check("in_ready_before_accept", 67'(in_ready), 67'd1);
    in_valid  = 1'b1;
    number    = n;
    sq_root   = s;
    cube_root = c;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // wait for the result (inputs toggled as noise meanwhile), compare, optionally backpressure
  task automatic collect(input int hold);
    int lat;
    logic [66:0] e;
    out_ready = (hold == 0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      in_valid  = 1'($urandom_range(0, 1));
      number    = $urandom;
      sq_root   = 16'($urandom);
      cube_root = 11'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 67'(lat), 67'd38);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 67'd0;
    check("is_square", 67'(is_square), 67'(e[66]));
    check("is_cube",   67'(is_cube),   67'(e[65]));
    check("root_err",  67'(root_err),  67'(e[64]));
    check("sq_rem",    67'(sq_rem),    67'(e[63:32]));
    check("cb_rem",    67'(cb_rem),    67'(e[31:0]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", 67'(out_valid), 67'd1);
      check("hold_in_ready",  67'(in_ready),  67'd0);
      check("hold_fields",    fields(),       e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_out_valid", 67'(out_valid), 67'd0);
    check("post_hs_in_ready",  67'(in_ready),  67'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    number    = 32'd0;
    sq_root   = 16'd0;
    cube_root = 11'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  67'(in_ready),  67'd1);
    check("rst_out_valid", 67'(out_valid), 67'd0);
    check("rst_fields",    fields(),       67'd0);
    rst = 1'b0;
    @(negedge clk);

    drive(32'd64, 16'd8, 11'd4);              collect(0);
    drive(32'd50, 16'd7, 11'd3);              collect(0);
    drive(32'd0, 16'd0, 11'd0);               collect(0);
    drive(32'hFFFF_FFFF, 16'd65535, 11'd1625); collect(0);
    // backpressure, then a back-to-back triple on the cycle after release
    drive(32'd10, 16'd4, 11'd3);              collect(5);
    drive(32'd64, 16'd8, 11'd4);              collect(0);

    for (int k = 0; k < 4; k++) begin
      drive($urandom, 16'($urandom_range(0, 65535)), 11'($urandom_range(0, 2047)));
      collect(0);
    end

    // reset one cycle at cycle 20 of a computation; the in-flight triple is dropped
    drive(32'd50, 16'd7, 11'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("midrst_in_ready",  67'(in_ready),  67'd1);
    check("midrst_out_valid", 67'(out_valid), 67'd0);
    check("midrst_fields",    fields(),       67'd0);
    repeat (40) @(negedge clk);
    check("midrst_no_late_result", 67'(out_valid), 67'd0);
    drive(32'd64, 16'd8, 11'd4);              collect(0);

    check("queue_empty", 67'(exp_q.size()), 67'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
